// File: rtl/sd_emmc_cmd_arbiter.sv
// sd_emmc_cmd_arbiter
// Collects command requests from N_CH sources, arbitrates them (round-robin
// or fixed priority), issues one command at a time to the command serial
// host and returns completion, response and timeout status to the owner.
module sd_emmc_cmd_arbiter #(
    parameter int N_CH   = 4,
    parameter int CMD_W  = 40,
    parameter int SET_W  = 2,
    parameter int RESP_W = 120,
    parameter int TO_W   = 24,
    parameter int RR_EN  = 1
) (
    input  logic                    sd_clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         start_xfr_i,
    input  logic [N_CH*CMD_W-1:0]   cmd_i,
    input  logic [N_CH*SET_W-1:0]   setting_i,
    input  logic [TO_W-1:0]         timeout_cycles,
    input  logic                    finish_i,
    input  logic [RESP_W-1:0]       response_i,
    input  logic                    crc_ok_i,
    input  logic                    index_ok_i,
    output logic [CMD_W-1:0]        cmd_o,
    output logic [SET_W-1:0]        setting_o,
    output logic                    start_xfr_o,
    output logic [N_CH-1:0]         grant_o,
    output logic                    busy_o,
    output logic [N_CH-1:0]         done_o,
    output logic [N_CH-1:0]         timeout_o,
    output logic [N_CH-1:0]         drop_o,
    output logic [RESP_W-1:0]       response_o,
    output logic                    crc_ok_o,
    output logic                    index_ok_o
);

    // state | meaning
    // IDLE  | no transaction; grant the next pending channel if any
    // ISSUE | start_xfr_o pulse to the serial host
    // WAIT  | waiting for finish_i or timeout expiry
    // DONE  | done_o/timeout_o pulse to the owner, release grant
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam int PTR_W = $clog2(N_CH);

    state_t               state_q, state_d;
    logic [N_CH-1:0]      pending_q;
    logic [CMD_W-1:0]     cmd_lat_q [N_CH];
    logic [SET_W-1:0]     set_lat_q [N_CH];
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     grant_idx_q;
    logic [TO_W-1:0]      to_cnt_q;
    logic                 to_en_q;
    logic                 to_flag_q;

    logic                 win_valid;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     cand;
    logic [N_CH-1:0]      win_onehot;
    logic [N_CH-1:0]      grant_clr;
    logic                 expire;

    // Winner search: the candidate closest after the pointer (or lowest index)
    // is visited last, so it overrides the others.
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
        for (int i = N_CH; i >= 1; i--) begin
            if (RR_EN != 0) cand = PTR_W'((int'(rr_ptr_q) + i) % N_CH);
            else            cand = PTR_W'(i - 1);
            if (pending_q[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot[win_idx] = win_valid;
    end

    assign grant_clr = (state_q == S_IDLE) ? win_onehot : '0;
    assign expire    = to_en_q && (to_cnt_q == TO_W'(1));

    // Request latches; a request coinciding with its own grant stays pending.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            pending_q <= '0;
            drop_o    <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cmd_lat_q[k] <= '0;
                set_lat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                drop_o[k] <= 1'b0;
                if (start_xfr_i[k]) begin
                    pending_q[k] <= 1'b1;
                    cmd_lat_q[k] <= cmd_i[k*CMD_W +: CMD_W];
                    set_lat_q[k] <= setting_i[k*SET_W +: SET_W];
                    drop_o[k]    <= pending_q[k] & ~grant_clr[k];
                end else if (grant_clr[k]) begin
                    pending_q[k] <= 1'b0;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge sd_clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and decoded outputs.
    always_comb begin
        state_d     = state_q;
        start_xfr_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = '0;
        timeout_o   = '0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (win_valid) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                start_xfr_o = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (finish_i || expire) state_d = S_DONE;
            end
            S_DONE: begin
                done_o    = grant_o;
                timeout_o = to_flag_q ? grant_o : '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction datapath: grant/command capture, timeout counter, results.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            grant_o     <= '0;
            grant_idx_q <= '0;
            cmd_o       <= '0;
            setting_o   <= '0;
            rr_ptr_q    <= PTR_W'(N_CH - 1);
            to_cnt_q    <= '0;
            to_en_q     <= 1'b0;
            to_flag_q   <= 1'b0;
            response_o  <= '0;
            crc_ok_o    <= 1'b0;
            index_ok_o  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        grant_o     <= win_onehot;
                        grant_idx_q <= win_idx;
                        cmd_o       <= cmd_lat_q[win_idx];
                        setting_o   <= set_lat_q[win_idx];
                        to_cnt_q    <= timeout_cycles;
                        to_en_q     <= (timeout_cycles != '0);
                        to_flag_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (finish_i) begin
                        response_o <= response_i;
                        crc_ok_o   <= crc_ok_i;
                        index_ok_o <= index_ok_i;
                    end else if (expire) begin
                        to_flag_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q - TO_W'(1);
                    end
                end
                S_DONE: begin
                    rr_ptr_q <= grant_idx_q;
                    grant_o  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
